// File: rtl/clock_sync_multi_if.sv
// Bus-side signal bundle for clock_sync_multi: raw MCCLK/strobe inputs and the
// qualified edge, timing and strobe outputs seen by the bus-cycle state machine.
interface clock_sync_multi_if #(
    parameter int NUM_STROBES = 3,
    parameter int DW          = 6,
    parameter int CNT_W       = 5
);
    logic                   MCCLK;
    logic [NUM_STROBES-1:0] STROBE_N;
    logic [DW-1:0]          DELAY_SEL;
    logic                   MCCLK_RISING;
    logic                   MCCLK_FALLING;
    logic                   MCCLK_FALLING_EARLY;
    logic [CNT_W-1:0]       PHASE;
    logic [CNT_W-1:0]       PERIOD;
    logic                   LOCKED;
    logic [NUM_STROBES-1:0] STROBE_LATCH;

    modport master (
        output MCCLK, STROBE_N, DELAY_SEL,
        input  MCCLK_RISING, MCCLK_FALLING, MCCLK_FALLING_EARLY,
        input  PHASE, PERIOD, LOCKED, STROBE_LATCH
    );

    modport slave (
        input  MCCLK, STROBE_N, DELAY_SEL,
        output MCCLK_RISING, MCCLK_FALLING, MCCLK_FALLING_EARLY,
        output PHASE, PERIOD, LOCKED, STROBE_LATCH
    );
endinterface

// File: rtl/clock_sync_multi.sv
// MCCLK synchroniser with edge strobes, period measurement, lock and early-fall
// prediction, plus per-channel strobe qualification. Optional: CLKSYNC_GLITCH_FILTER_EN.
module clock_sync_multi #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_STROBES = 3,
    parameter int MAX_DELAY   = 32,
    parameter int DW          = 6,
    parameter int CNT_W       = 5,
    parameter int EARLY       = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic              SYSCLK,
    input  logic              RESET_N,
    clock_sync_multi_if.slave bus
);
    localparam int WARM    = SYNC_STAGES + 1;
    localparam int WARM_W  = $clog2(WARM + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]   PHASE_MAX = '1;
    localparam logic [DW-1:0]      DMAX      = DW'(MAX_DELAY);
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_COUNT);

    // MCCLK path state
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [WARM_W-1:0]      warm_q, warm_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   early_q, early_d;
    logic [CNT_W-1:0]       phase_q, phase_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   valid_q, valid_d;
    logic [MATCH_W-1:0]     match_q, match_d;
    logic                   locked_q, locked_d;

    logic                   warm_done;
    logic                   sat;
    logic                   close;
    logic [CNT_W:0]         new_w, old_w;

    // Strobe path state
    logic [MAX_DELAY-1:0]   dly_q [NUM_STROBES];
    logic [MAX_DELAY-1:0]   dly_d [NUM_STROBES];
    logic [NUM_STROBES-1:0] latch_q, latch_d;
    logic [NUM_STROBES-1:0] win_hi;
    logic [DW-1:0]          d_eff;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves
        // a value unassigned and no latch is inferred.
        sync_d    = {sync_q[SYNC_STAGES-2:0], bus.MCCLK};
        hist_d    = sync_q[SYNC_STAGES-1];
        warm_done = (warm_q == WARM_W'(WARM));
        warm_d    = warm_done ? warm_q : warm_q + WARM_W'(1);
        rise_d    = warm_done &  sync_q[SYNC_STAGES-1] & ~hist_q;
        fall_d    = warm_done & ~sync_q[SYNC_STAGES-1] &  hist_q;

        phase_d   = phase_q;
        if (fall_d) begin
            phase_d = '0;
        end else if (phase_q != PHASE_MAX) begin
            phase_d = phase_q + CNT_W'(1);
        end
        sat = !fall_d && (phase_d == PHASE_MAX);

        period_d = period_q;
        valid_d  = valid_q;
        match_d  = match_q;
        if (fall_d) begin
            valid_d = 1'b1;
            // A saturated PHASE already dropped valid, so the wrap of PHASE+1 never lands here.
            period_d = valid_q ? phase_q + CNT_W'(1) : '0;
        end

        new_w = {1'b0, period_d};
        old_w = {1'b0, period_q};
        close = (new_w <= old_w + (CNT_W+1)'(1)) && (old_w <= new_w + (CNT_W+1)'(1));

        if (fall_d) begin
            if (period_d != '0 && close) begin
                match_d = (match_q == MATCH_MAX) ? match_q : match_q + MATCH_W'(1);
            end else begin
                match_d = '0;
            end
        end else if (sat) begin
            valid_d = 1'b0;
            match_d = '0;
        end

        locked_d = (match_d == MATCH_MAX);
        // Evaluated on next-state values so the pulse lines up with the PHASE it names.
        early_d  = locked_d && (period_d > CNT_W'(EARLY)) &&
                   (phase_d == period_d - CNT_W'(EARLY));
    end

    always_comb begin
        d_eff   = (bus.DELAY_SEL > DMAX) ? DMAX : bus.DELAY_SEL;
        win_hi  = '0;
        latch_d = '0;
        for (int i = 0; i < NUM_STROBES; i++) begin
            dly_d[i] = {dly_q[i][MAX_DELAY-2:0], bus.STROBE_N[i]};
            for (int j = 0; j < MAX_DELAY; j++) begin
`ifdef CLKSYNC_GLITCH_FILTER_EN
                if (DW'(j) < d_eff) begin
                    win_hi[i] = win_hi[i] | dly_q[i][j];
                end
`else
                if (DW'(j + 1) == d_eff) begin
                    win_hi[i] = dly_q[i][j];
                end
`endif
            end
            latch_d[i] = ~(bus.STROBE_N[i] | win_hi[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    always_ff @(negedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q   <= '0;
            hist_q   <= 1'b0;
            warm_q   <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            early_q  <= 1'b0;
            phase_q  <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            match_q  <= '0;
            locked_q <= 1'b0;
            latch_q  <= '0;
            // NOTE: the delay lines are reset on purpose: filling them with idle
            // ones is what blocks qualification for d cycles after release.
            for (int i = 0; i < NUM_STROBES; i++) begin
                dly_q[i] <= '1;
            end
        end else begin
            sync_q   <= sync_d;
            hist_q   <= hist_d;
            warm_q   <= warm_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            early_q  <= early_d;
            phase_q  <= phase_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            match_q  <= match_d;
            locked_q <= locked_d;
            latch_q  <= latch_d;
            for (int i = 0; i < NUM_STROBES; i++) begin
                dly_q[i] <= dly_d[i];
            end
        end
    end

    assign bus.MCCLK_RISING        = rise_q;
    assign bus.MCCLK_FALLING       = fall_q;
    assign bus.MCCLK_FALLING_EARLY = early_q;
    assign bus.PHASE               = phase_q;
    assign bus.PERIOD              = period_q;
    assign bus.LOCKED              = locked_q;
    assign bus.STROBE_LATCH        = latch_q;
endmodule

// File: tb/tb_clock_sync_multi.sv
// Self-checking bench for clock_sync_multi: an edge-history model checked every
// cycle, plus directed MCCLK/strobe scenarios with hand-computed expectations.
module tb_clock_sync_multi;
    localparam int LAT  = 2;     // synchroniser depth
    localparam int WARM = 3;     // suppressed edges after release
    localparam int SAT  = 31;    // PHASE saturation value
    localparam int LOCKN = 4;
    localparam int EARLYN = 2;
    localparam int MAXD = 32;
    localparam int MAXE = 4096;
`ifdef CLKSYNC_GLITCH_FILTER_EN
    localparam int GLITCH_LAT = 22;
`else
    localparam int GLITCH_LAT = 16;
`endif

    logic SYSCLK = 1'b1;
    logic RESET_N;
    always #5 SYSCLK = ~SYSCLK;

    clock_sync_multi_if #(.NUM_STROBES(3), .DW(6), .CNT_W(5)) bus ();

    clock_sync_multi dut (
        .SYSCLK  (SYSCLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit armed    = 1'b0;
    int early_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         mc_h [MAXE];
    logic [2:0] sn_h [MAXE];
    int n = 0, last_fall = 0, streak = 0, gap, new_p, diff, d;
    bit have_fall = 1'b0, ok;
    bit e_rise = 0, e_fall = 0, e_early = 0, e_locked = 0;
    int e_phase = 0, e_period = 0;
    logic [2:0] e_latch = '0;

    function automatic bit mc_at(input int m);
        return (m <= 0) ? 1'b0 : mc_h[m];
    endfunction

    function automatic bit sn_at(input int ch, input int m);
        return (m <= 0) ? 1'b1 : sn_h[m][ch];
    endfunction

    always @(negedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            n = 0; last_fall = 0; streak = 0; have_fall = 1'b0;
            e_rise = 0; e_fall = 0; e_early = 0; e_locked = 0;
            e_phase = 0; e_period = 0; e_latch = '0;
        end else if (n < MAXE - 1) begin
            n++;
            mc_h[n] = bus.MCCLK;
            sn_h[n] = bus.STROBE_N;
            e_rise = (n > WARM) &&  mc_at(n - LAT) && !mc_at(n - LAT - 1);
            e_fall = (n > WARM) && !mc_at(n - LAT) &&  mc_at(n - LAT - 1);
            if (e_fall) begin
                gap   = n - last_fall;
                new_p = (have_fall && gap <= SAT) ? gap : 0;
                diff  = new_p - e_period;
                if (new_p != 0 && diff <= 1 && diff >= -1)
                    streak = (streak < LOCKN) ? streak + 1 : LOCKN;
                else
                    streak = 0;
                e_period  = new_p;
                last_fall = n;
                have_fall = 1'b1;
            end else if (n - last_fall >= SAT) begin
                streak = 0;
            end
            e_phase  = (n - last_fall > SAT) ? SAT : n - last_fall;
            e_locked = (streak == LOCKN);
            e_early  = e_locked && e_period > EARLYN && e_phase == e_period - EARLYN;
            d = (int'(bus.DELAY_SEL) > MAXD) ? MAXD : int'(bus.DELAY_SEL);
            for (int ch = 0; ch < 3; ch++) begin
                ok = !sn_at(ch, n);
`ifdef CLKSYNC_GLITCH_FILTER_EN
                for (int j = 1; j <= d; j++) if (sn_at(ch, n - j)) ok = 1'b0;
`else
                if (d > 0 && sn_at(ch, n - d)) ok = 1'b0;
`endif
                e_latch[ch] = ok;
            end
        end
    end

    always @(posedge SYSCLK) begin
        if (armed) begin
            check("rising",  bus.MCCLK_RISING,        e_rise);
            check("falling", bus.MCCLK_FALLING,       e_fall);
            check("early",   bus.MCCLK_FALLING_EARLY, e_early);
            check("phase",   bus.PHASE,               e_phase);
            check("period",  bus.PERIOD,              e_period);
            check("locked",  bus.LOCKED,              e_locked);
            check("latch",   bus.STROBE_LATCH,        e_latch);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int k);
        repeat (k) begin
            @(negedge SYSCLK);
            #1;
            early_seen += int'(bus.MCCLK_FALLING_EARLY);
        end
    endtask

    task automatic mc_cycles(input int hi, input int lo, input int count);
        repeat (count) begin
            bus.MCCLK = 1'b1; tick(hi);
            bus.MCCLK = 1'b0; tick(lo);
        end
    endtask

    // Edges elapsed (from the caller's point) until STROBE_LATCH[ch] is seen high; -1 if never.
    task automatic measure(input int ch, input int limit, output int lat);
        lat = -1;
        for (int j = 1; j <= limit; j++) begin
            @(negedge SYSCLK);
            #1;
            if (bus.STROBE_LATCH[ch]) begin
                lat = j;
                break;
            end
        end
    endtask

    int rises;
    int lat;

    initial begin
        RESET_N       = 1'b0;
        bus.MCCLK     = 1'b1;
        bus.STROBE_N  = '1;
        bus.DELAY_SEL = '0;
        repeat (2) @(posedge SYSCLK);
        armed = 1'b1;
        #1;
        check("reset_rising",  bus.MCCLK_RISING, 0);
        check("reset_falling", bus.MCCLK_FALLING, 0);
        check("reset_early",   bus.MCCLK_FALLING_EARLY, 0);
        check("reset_phase",   bus.PHASE, 0);
        check("reset_period",  bus.PERIOD, 0);
        check("reset_locked",  bus.LOCKED, 0);
        check("reset_latch",   bus.STROBE_LATCH, 0);
        RESET_N = 1'b1;

        // MCCLK held high through release: no spurious rising edge
        rises = 0;
        repeat (20) begin
            @(negedge SYSCLK); #1;
            rises += int'(bus.MCCLK_RISING);
        end
        check("no_spurious_rise", rises, 0);
        check("phase_after_20", bus.PHASE, 20);

        // Period-16 square wave: locks, early pulse once per period
        mc_cycles(8, 8, 10);
        check("p16_period", bus.PERIOD, 16);
        check("p16_locked", bus.LOCKED, 1);
        early_seen = 0;
        mc_cycles(8, 8, 2);
        check("p16_early_count", early_seen, 2);

        // One long period of 20 breaks lock, then relock at 16
        mc_cycles(12, 8, 1);
        check("p20_period", bus.PERIOD, 20);
        check("p20_unlocked", bus.LOCKED, 0);
        mc_cycles(8, 8, 6);
        check("relock", bus.LOCKED, 1);

        // MCCLK stopped: PHASE saturates, lock lost, next fall invalid
        tick(40);
        check("stop_phase", bus.PHASE, 31);
        check("stop_unlocked", bus.LOCKED, 0);
        bus.MCCLK = 1'b1; tick(4);
        bus.MCCLK = 0;    tick(4);
        check("restart_period", bus.PERIOD, 0);

        // PERIOD == EARLY: locks but never predicts
        mc_cycles(1, 1, 8);
        check("p2_period", bus.PERIOD, 2);
        check("p2_locked", bus.LOCKED, 1);
        early_seen = 0;
        mc_cycles(1, 1, 4);
        check("p2_no_early", early_seen, 0);

        // PERIOD == EARLY+1: smallest period that predicts
        mc_cycles(2, 1, 10);
        check("p3_period", bus.PERIOD, 3);
        check("p3_locked", bus.LOCKED, 1);
        early_seen = 0;
        mc_cycles(2, 1, 4);
        check("p3_early_count", early_seen, 4);

        // Strobe qualification
        bus.DELAY_SEL = 6'd15;
        bus.STROBE_N[0] = 1'b0;
        measure(0, 40, lat);
        check("dtack_d15", lat, 16);
        bus.STROBE_N[0] = 1'b1; tick(2);

        bus.DELAY_SEL = 6'd0;
        bus.STROBE_N[0] = 1'b0;
        measure(0, 40, lat);
        check("dtack_d0", lat, 1);
        bus.STROBE_N[0] = 1'b1; tick(2);

        bus.DELAY_SEL = 6'd15;
        bus.STROBE_N[1] = 1'b0;
        fork
            begin
                tick(5);
                bus.STROBE_N[1] = 1'b1;
                tick(1);
                bus.STROBE_N[1] = 1'b0;
            end
            measure(1, 40, lat);
        join
        check("vpa_glitch", lat, GLITCH_LAT);
        bus.STROBE_N[1] = 1'b1; tick(2);

        bus.DELAY_SEL = 6'd40;
        bus.STROBE_N[2] = 1'b0;
        measure(2, 60, lat);
        check("berr_clamped", lat, 33);
        bus.STROBE_N[2] = 1'b1; tick(40);

        // DELAY_SEL shortened mid-window takes effect at once
        bus.DELAY_SEL = 6'd10;
        bus.STROBE_N[0] = 1'b0;
        tick(3);
        bus.DELAY_SEL = 6'd2;
        measure(0, 20, lat);
        check("dsel_change", lat, 1);

        // Reset mid-strobe clears the latch and refills the window
        bus.DELAY_SEL = 6'd4;
        tick(2);
        check("pre_reset_latch", bus.STROBE_LATCH[0], 1);
        @(posedge SYSCLK); #1;
        RESET_N = 1'b0;
        #1;
        check("mid_reset_latch", bus.STROBE_LATCH, 0);
        repeat (2) @(posedge SYSCLK);
        #1;
        RESET_N = 1'b1;
        measure(0, 20, lat);
        check("post_reset_refill", lat, 5);
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clock_sync_multi.md
Name: clock_sync_multi

Overview:
Parametrised successor to the MCCLK edge/DTACK qualifier. It synchronises MCCLK and produces single-cycle edge strobes, measures the MCCLK period in SYSCLK cycles, declares lock, and issues a predictive pulse ahead of the next falling edge. It also qualifies NUM_STROBES active-low bus strobes (bit 0 = DTACK, then VPA, BERR) through a runtime-selectable delay window. It sits between the raw 68k bus pins and the bus-cycle state machine.

Parameters:
SYNC_STAGES, 2, MCCLK synchroniser depth (>=2)
NUM_STROBES, 3, number of active-low strobe channels
MAX_DELAY, 32, strobe delay-line depth per channel (>=2)
DW, 6, width of DELAY_SEL; must hold MAX_DELAY
CNT_W, 5, width of PHASE/PERIOD counters
EARLY, 2, cycles by which MCCLK_FALLING_EARLY leads predicted MCCLK_FALLING
LOCK_COUNT, 4, consecutive matching periods required for LOCKED

Ports:
SYSCLK  in  1  system clock; all state updates on falling edge
RESET_N  in  1  asynchronous active-low reset
MCCLK  in  1  asynchronous 68k bus clock
STROBE_N  in  NUM_STROBES  asynchronous active-low strobes, bit0=DTACK
DELAY_SEL  in  DW  qualification window length in SYSCLK cycles, quasi-static
MCCLK_RISING  out  1  one-cycle pulse per MCCLK rising edge
MCCLK_FALLING  out  1  one-cycle pulse per MCCLK falling edge
MCCLK_FALLING_EARLY  out  1  one-cycle predictive pulse, EARLY cycles before next MCCLK_FALLING
PHASE  out  CNT_W  SYSCLK cycles since last MCCLK_FALLING
PERIOD  out  CNT_W  last measured falling-to-falling period; 0 = invalid
LOCKED  out  1  period stable
STROBE_LATCH  out  NUM_STROBES  qualified strobe, active high

Behaviour:
- Reset (async, RESET_N low): sync chain and edge history 0; delay lines all ones (idle); all outputs 0; PHASE 0; PERIOD 0; match counter 0; period-valid flag 0. Release is honoured on the next SYSCLK falling edge.
- Edge strobes are suppressed for the first SYNC_STAGES+1 cycles after reset release, so no spurious edge is produced from the reset state.
- Edge latency: an MCCLK transition first sampled at edge k yields a RISING/FALLING pulse in the register at edge k+SYNC_STAGES. The pulse is exactly one cycle wide.
- PHASE: loads 0 in the cycle MCCLK_FALLING is asserted; otherwise increments each cycle and saturates at 2^CNT_W-1.
- On each FALLING:
  - If the valid flag is 0, PERIOD<=0 and the valid flag is set.
  - Otherwise PERIOD<=PHASE+1, where PHASE is the previous value.
- Saturation: if PHASE reaches all ones, the valid flag, match counter and LOCKED are all cleared.
- Match counter, updated at each FALLING where a new PERIOD is computed:
  - If the new value is nonzero and |new−old PERIOD| <= 1, the counter increments, saturating at LOCK_COUNT.
  - Otherwise it is cleared to 0.
  - LOCKED = (match counter == LOCK_COUNT), registered.
- MCCLK_FALLING_EARLY: asserted for one cycle when LOCKED && PERIOD > EARLY && PHASE == PERIOD−EARLY. Never asserted when unlocked or when PERIOD <= EARLY.
- Simultaneous events: if a FALLING coincides with PHASE saturation, the FALLING wins. PHASE<=0, but PERIOD<=0 and LOCKED is cleared.
- Strobe channels (each independent):
  - Shift register D[0..MAX_DELAY-1]; D[0]<=STROBE_N[i] each cycle.
  - Effective delay d = min(DELAY_SEL, MAX_DELAY).
  - d = 0: STROBE_LATCH[i] <= ~STROBE_N[i].
  - d >= 1: STROBE_LATCH[i] <= ~(STROBE_N[i] | D[d−1]), i.e. low now and low d cycles ago.
  - A DELAY_SEL change takes effect on the next cycle with no flush.
  - Reset mid-strobe clears STROBE_LATCH, and refilling the delay line prevents assertion for d cycles after release.

Optional Feature:
CLKSYNC_GLITCH_FILTER_EN
- Defined: for d >= 1, STROBE_LATCH[i] requires STROBE_N[i] and every tap D[0..d−1] to be low, so the strobe must be continuously low across the window. Any one-cycle high glitch deasserts the latch and restarts qualification.
- Undefined: endpoint-only check as above (legacy DTACK behaviour).

Test Plan:
- Reset → all outputs 0. Hold MCCLK=1 through release → no MCCLK_RISING pulse in the first 20 cycles.
- MCCLK square wave, period 16 SYSCLK → FALLING/RISING pulses 16 apt. PERIOD sequence 0,16,16,... LOCKED rises after the 6th FALLING. EARLY pulse while PHASE==14, 2 cycles before each FALLING.
- Locked at 16, then a single period of 20 → match counter 0, LOCKED drops after that FALLING, no EARLY pulse. Relocks after 4 further matching periods.
- MCCLK stopped for more than 31 cycles → PHASE holds 31, LOCKED=0. Next FALLING gives PERIOD=0.
- DELAY_SEL=15, STROBE_N[0] driven low at edge k and held → STROBE_LATCH[0]=1 at edge k+16. DELAY_SEL=0 → asserts at edge k+1.
- DELAY_SEL=15, STROBE_N[1] low with a one-cycle high at k+5 → endpoint mode: asserts at k+16. With CLKSYNC_GLITCH_FILTER_EN: asserts at k+22.
